// File: rtl/seq_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM states, default width
// and the detector pattern constant.
package seq_pattern_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int unsigned SEQ_PAT_W_DEFAULT = 4;
  localparam logic [3:0]  SEQ_PAT_0111      = 4'b0111;

endpackage

// File: rtl/seq_pattern_gen_piso.sv
// seq_piso: W-bit parallel-in/serial-out shift register, MSB out, load has priority
// over shift.
module seq_piso #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         sout
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sout = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: MSB-first frames, repeat count and inter-frame gap.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to each frame.
module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int unsigned PAT_W = SEQ_PAT_W_DEFAULT,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             frame,
  output logic             busy,
  output logic             done
);

`ifdef SEQ_GEN_PARITY_EN
  localparam int unsigned FRAME_LEN = PAT_W + 1;
`else
  localparam int unsigned FRAME_LEN = PAT_W;
`endif
  localparam int unsigned      CNT_W    = $clog2(PAT_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             out_q, out_d;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SEQ_GEN_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             piso_load, piso_shift, piso_sout;
  logic [PAT_W-1:0] piso_din;

  // The shift register holds the bits still to come; the bit on the line lives
  // in out_q, so the first bit of a frame is registered directly from the source.
  seq_piso #(.W(PAT_W)) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (piso_load),
    .shift(piso_shift),
    .din  (piso_din),
    .sout (piso_sout)
  );

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    out_d      = 1'b0;
    frame_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_din   = {pat_q[PAT_W-2:0], 1'b0};
`ifdef SEQ_GEN_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d     = pattern;
          rep_d     = reps;
          gap_d     = gap;
`ifdef SEQ_GEN_PARITY_EN
          par_d     = ^pattern;
`endif
          piso_din  = {pattern[PAT_W-2:0], 1'b0};
          piso_load = 1'b1;
          bit_cnt_d = '0;
          out_d     = pattern[PAT_W-1];
          frame_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (bit_cnt_q == LAST_IDX) begin
          if (rep_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            rep_d  = rep_q - REP_W'(1);
            busy_d = 1'b1;
            if (gap_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_q;
            end else begin
              piso_load = 1'b1;
              bit_cnt_d = '0;
              out_d     = pat_q[PAT_W-1];
              frame_d   = 1'b1;
            end
          end
        end else begin
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          piso_shift = 1'b1;
          busy_d     = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
          out_d      = (bit_cnt_q == CNT_W'(PAT_W - 1)) ? par_q : piso_sout;
`else
          out_d      = piso_sout;
`endif
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d   = S_SEND;
          gap_cnt_d = '0;
          piso_load = 1'b1;
          bit_cnt_d = '0;
          out_d     = pat_q[PAT_W-1];
          frame_d   = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      bit_cnt_q <= '0;
      out_q     <= 1'b0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      out_q     <= out_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign out   = out_q;
  assign frame = frame_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
